// File: rtl/array_collector.sv
// Collects DEPTH words from a sync/notify input channel and offers them as one array on the output channel.
// Array offered 1 cycle after the last input transfer; input stalls (notify low) until the array is taken.
module array_collector #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 2,
  parameter int REVERSE       = 0,
  parameter int CLEAR_ON_SEND = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] b_in,
  input  logic                    b_in_sync,
  output logic                    b_in_notify,
  output logic [DEPTH*WIDTH-1:0]  b_out,
  input  logic                    b_out_sync,
  output logic                    b_out_notify
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW-1:0] IDX_START = (REVERSE != 0) ? IDXW'(DEPTH - 1) : '0;
  localparam logic [IDXW-1:0] IDX_LAST  = (REVERSE != 0) ? '0 : IDXW'(DEPTH - 1);

  typedef enum logic {S_FILL = 1'b0, S_SEND = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_notify;
  logic             r_out_notify;
  logic             w_in_notify_nxt;
  logic             w_out_notify_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_arr [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_at_last;

  assign w_in_xfer  = r_in_notify & b_in_sync;
  assign w_out_xfer = r_out_notify & b_out_sync;
  assign w_at_last  = (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FILL;
      r_in_notify  <= 1'b1;
      r_out_notify <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_in_notify  <= w_in_notify_nxt;
      r_out_notify <= w_out_notify_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_in_xfer && w_at_last) w_state_nxt = S_SEND;
      S_SEND:  if (w_out_xfer)             w_state_nxt = S_FILL;
      default:                             w_state_nxt = S_FILL;
    endcase
  end

  // Notifies are registered copies of the next state, so they never overlap.
  always_comb begin
    w_in_notify_nxt  = (w_state_nxt == S_FILL);
    w_out_notify_nxt = (w_state_nxt == S_SEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= IDX_START;
    end else if (w_out_xfer) begin
      r_idx <= IDX_START;
    end else if (w_in_xfer && !w_at_last) begin
      r_idx <= (REVERSE != 0) ? r_idx - 1'b1 : r_idx + 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_elem
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_arr[i] <= '0;
      end else if (w_in_xfer && (r_idx == IDXW'(i))) begin
        r_arr[i] <= b_in;
      end else if (w_out_xfer && (CLEAR_ON_SEND != 0)) begin
        r_arr[i] <= '0;
      end
    end
    assign b_out[i*WIDTH +: WIDTH] = r_arr[i];
  end

  assign b_in_notify  = r_in_notify;
  assign b_out_notify = r_out_notify;

endmodule

// File: tb/tb_array_collector.sv
// Scoreboarded bench: six array_collector configurations driven one at a time with directed vectors.
`timescale 1ns/1ps
module tb_array_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din [6];
  logic [5:0]  isync;
  logic [5:0]  osync;
  wire  [5:0]  in_n;
  wire  [5:0]  out_n;
  wire  [63:0]  bo0;
  wire  [127:0] bo1;
  wire  [127:0] bo2;
  wire  [95:0]  bo3;
  wire  [95:0]  bo4;
  wire  [15:0]  bo5;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int           inst;
    logic [127:0] dat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  array_collector #(.WIDTH(32), .DEPTH(2), .REVERSE(0), .CLEAR_ON_SEND(0)) u0 (
    .clk(clk), .rst(rst), .b_in(din[0]), .b_in_sync(isync[0]), .b_in_notify(in_n[0]),
    .b_out(bo0), .b_out_sync(osync[0]), .b_out_notify(out_n[0]));
  array_collector #(.WIDTH(32), .DEPTH(4), .REVERSE(1), .CLEAR_ON_SEND(0)) u1 (
    .clk(clk), .rst(rst), .b_in(din[1]), .b_in_sync(isync[1]), .b_in_notify(in_n[1]),
    .b_out(bo1), .b_out_sync(osync[1]), .b_out_notify(out_n[1]));
  array_collector #(.WIDTH(32), .DEPTH(4), .REVERSE(0), .CLEAR_ON_SEND(0)) u2 (
    .clk(clk), .rst(rst), .b_in(din[2]), .b_in_sync(isync[2]), .b_in_notify(in_n[2]),
    .b_out(bo2), .b_out_sync(osync[2]), .b_out_notify(out_n[2]));
  array_collector #(.WIDTH(32), .DEPTH(3), .REVERSE(0), .CLEAR_ON_SEND(1)) u3 (
    .clk(clk), .rst(rst), .b_in(din[3]), .b_in_sync(isync[3]), .b_in_notify(in_n[3]),
    .b_out(bo3), .b_out_sync(osync[3]), .b_out_notify(out_n[3]));
  array_collector #(.WIDTH(32), .DEPTH(3), .REVERSE(0), .CLEAR_ON_SEND(0)) u4 (
    .clk(clk), .rst(rst), .b_in(din[4]), .b_in_sync(isync[4]), .b_in_notify(in_n[4]),
    .b_out(bo4), .b_out_sync(osync[4]), .b_out_notify(out_n[4]));
  array_collector #(.WIDTH(8), .DEPTH(2), .REVERSE(0), .CLEAR_ON_SEND(0)) u5 (
    .clk(clk), .rst(rst), .b_in(din[5][7:0]), .b_in_sync(isync[5]), .b_in_notify(in_n[5]),
    .b_out(bo5), .b_out_sync(osync[5]), .b_out_notify(out_n[5]));

  function automatic logic [127:0] ob(int k);
    case (k)
      0:       return {64'd0, bo0};
      1:       return bo1;
      2:       return bo2;
      3:       return {32'd0, bo3};
      4:       return {32'd0, bo4};
      5:       return {112'd0, bo5};
      default: return '0;
    endcase
  endfunction

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: every output transfer pops the oldest expected array.
  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (!rst && out_n[k] && osync[k]) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: inst %0d delivered %h with nothing expected", k, ob(k));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("sb_inst%0d_id", k), k, e.inst);
          chk($sformatf("sb_inst%0d_data", k), ob(k), e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k, logic [127:0] d);
    exp_t e;
    e.inst = k;
    e.dat  = d;
    sb_q.push_back(e);
  endtask

  task automatic feed(int k, logic [31:0] v);
    din[k]   = v;
    isync[k] = 1'b1;
    tick();
    isync[k] = 1'b0;
  endtask

  task automatic drain(int k);
    int n = 0;
    while (!out_n[k] && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("drain%0d_offered", k), out_n[k], 1'b1);
    osync[k] = 1'b1;
    tick();
    osync[k] = 1'b0;
  endtask

  initial begin
    logic [7:0] vals [4];
    int idx, cyc, rise1, rise2;
    logic prev;

    for (int k = 0; k < 6; k++) din[k] = '0;
    isync = '0;
    osync = '0;
    rst   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rst%0d_in_notify", k), in_n[k], 1'b1);
      chk($sformatf("rst%0d_out_notify", k), out_n[k], 1'b0);
      chk($sformatf("rst%0d_bout", k), ob(k), '0);
    end

    // Basic fill, sync held high: 5 then -3
    push(0, {32'hFFFF_FFFD, 32'd5});
    isync[0] = 1'b1;
    din[0]   = 32'd5;
    tick();
    chk("t1_in_notify_mid", in_n[0], 1'b1);
    chk("t1_out_notify_mid", out_n[0], 1'b0);
    din[0] = 32'hFFFF_FFFD;
    tick();
    isync[0] = 1'b0;
    chk("t1_in_notify_full", in_n[0], 1'b0);
    chk("t1_out_notify_full", out_n[0], 1'b1);
    chk("t1_elem0", bo0[31:0], 32'd5);
    chk("t1_elem1", bo0[63:32], 32'hFFFF_FFFD);
    drain(0);
    chk("t1_in_notify_back", in_n[0], 1'b1);
    chk("t1_out_notify_back", out_n[0], 1'b0);

    // Backpressure with producer pushing 99 into a full block
    feed(0, 32'd11);
    feed(0, 32'd12);
    push(0, {32'd12, 32'd11});
    isync[0] = 1'b1;
    din[0]   = 32'd99;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_notify", in_n[0], 1'b0);
      chk("bp_bout", bo0, {32'd12, 32'd11});
    end
    osync[0] = 1'b1;
    tick();
    osync[0] = 1'b0;
    isync[0] = 1'b0;
    chk("bp_in_notify_after", in_n[0], 1'b1);
    chk("bp_out_notify_after", out_n[0], 1'b0);
    chk("bp_bout_after", bo0, {32'd12, 32'd11});

    // Reverse fill, depth 4
    push(1, {32'd1, 32'd2, 32'd3, 32'd4});
    for (int i = 0; i < 4; i++) begin
      din[1]   = 32'(i + 1);
      isync[1] = 1'b1;
      tick();
      isync[1] = 1'b0;
      chk("t2_out_notify", out_n[1], (i == 3));
    end
    chk("t2_in_notify", in_n[1], 1'b0);
    drain(1);

    // Clear on send versus retain
    feed(3, 32'd7); feed(3, 32'd8); feed(3, 32'd9);
    push(3, {32'd9, 32'd8, 32'd7});
    drain(3);
    chk("t3_cleared", bo3, '0);
    chk("t3_clear_in_notify", in_n[3], 1'b1);
    feed(4, 32'd7); feed(4, 32'd8); feed(4, 32'd9);
    push(4, {32'd9, 32'd8, 32'd7});
    drain(4);
    chk("t3_retained", bo4, {32'd9, 32'd8, 32'd7});
    feed(4, 32'd1);
    chk("t3_overwrite0", bo4, {32'd9, 32'd8, 32'd1});
    feed(4, 32'd2);
    chk("t3_overwrite1", bo4, {32'd9, 32'd2, 32'd1});
    feed(4, 32'd3);
    push(4, {32'd3, 32'd2, 32'd1});
    drain(4);

    // Asynchronous reset between edges during a partial fill
    feed(2, 32'd10);
    feed(2, 32'd20);
    chk("t4_partial", bo2, {64'd0, 32'd20, 32'd10});
    #3 rst = 1'b1;
    #1;
    chk("t4_rst_bout", bo2, '0);
    chk("t4_rst_in_notify", in_n[2], 1'b1);
    chk("t4_rst_out_notify", out_n[2], 1'b0);
    #1 rst = 1'b0;
    for (int i = 1; i <= 4; i++) feed(2, 32'(i));
    push(2, {32'd4, 32'd3, 32'd2, 32'd1});
    drain(2);

    // Back-to-back streaming, 8-bit words
    vals[0] = 8'h7F; vals[1] = 8'h80; vals[2] = 8'h01; vals[3] = 8'h02;
    push(5, {8'h80, 8'h7F});
    push(5, {8'h02, 8'h01});
    osync[5] = 1'b1;
    idx = 0; cyc = 0; rise1 = -1; rise2 = -1; prev = 1'b0;
    while ((idx < 4 || sb_q.size() != 0) && cyc < 40) begin
      chk("t5_notify_exclusive", in_n[5] & out_n[5], 1'b0);
      if (out_n[5] && !prev) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      prev = out_n[5];
      if (idx < 4) begin
        isync[5] = 1'b1;
        if (in_n[5]) begin
          din[5] = {24'd0, vals[idx]};
          idx++;
        end
      end else begin
        isync[5] = 1'b0;
      end
      tick();
      cyc++;
    end
    osync[5] = 1'b0;
    isync[5] = 1'b0;
    chk("t5_completed", (idx == 4 && sb_q.size() == 0), 1'b1);
    chk("t5_first_offer_cycle", rise1, 2);
    chk("t5_period", rise2 - rise1, 3);

    repeat (2) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/array_collector.md
Name: array_collector

Overview:
- Parametrised successor to the two-element array capture block.
- Collects DEPTH signed words from a blocking input channel into an internal array, then presents the whole array on a blocking output channel.
- Adds configurable word width, array depth, fill order and post-send clearing.
- Sits between a scalar producer and an array consumer; both sides use the codebase's sync/notify handshake.

Parameters:
WIDTH, 32, bit width of each array element and of b_in (signed two's complement)
DEPTH, 2, number of elements in the array; legal range 1..256
REVERSE, 0, 0 = fill index 0 up to DEPTH-1; 1 = fill index DEPTH-1 down to 0
CLEAR_ON_SEND, 0, 1 = zero the array on each completed output transfer; 0 = retain contents

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
b_in  input  WIDTH  input data word
b_in_sync  input  1  producer has valid data on b_in
b_in_notify  output  1  block ready to accept a word
b_out  output  DEPTH*WIDTH  array contents; element i at bits [i*WIDTH +: WIDTH]
b_out_sync  input  1  consumer ready to take the array
b_out_notify  output  1  array complete and offered on b_out

Behaviour:
- Handshake rules:
  - Input transfer happens in a cycle where b_in_notify=1 and b_in_sync=1.
  - Output transfer happens in a cycle where b_out_notify=1 and b_out_sync=1.
  - Sync without the matching notify is ignored.
  - All outputs are registered.
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - array <= all zero, so b_out=0.
  - idx <= 0 (REVERSE=0) or DEPTH-1 (REVERSE=1).
  - state <= FILL, b_in_notify <= 1, b_out_notify <= 0.
  - A partially filled array is discarded.
- State FILL:
  - b_in_notify=1, b_out_notify=0.
  - On input transfer: array[idx] <= b_in.
  - If idx is not the last index, idx steps by +1 (REVERSE=0) or -1 (REVERSE=1).
  - If idx is the last index (DEPTH-1, or 0 when REVERSE=1): state <= SEND, b_in_notify <= 0, b_out_notify <= 1.
  - The new element and b_out_notify become visible together in the next cycle.
- State SEND:
  - b_in_notify=0; b_out is stable and b_out_notify=1 until the output transfer.
  - On output transfer: state <= FILL, b_in_notify <= 1, b_out_notify <= 0, idx <= start value.
  - If CLEAR_ON_SEND=1, array <= 0 in the same edge.
- Latency:
  - Last input transfer at cycle t gives b_out_notify=1 at t+1.
  - Output transfer at cycle u gives b_in_notify=1 at u+1.
  - Minimum period is DEPTH+1 cycles per array with sync held high.
- b_out visibility: b_out shows the array continuously, including partial fills during FILL. The consumer may only sample it during an output transfer.
- Index width: max(1, $clog2(DEPTH)). idx never leaves 0..DEPTH-1; no wrap beyond the range.
- DEPTH=1: every input transfer goes straight to SEND.
- Simultaneous syncs: b_in_sync and b_out_sync high together is legal. Only the one matching the current state acts; the two notifies are never both high.
- Data is stored bit-exact; no arithmetic or sign extension.

Test Plan:
- Reset then DEPTH=2, REVERSE=0, b_in_sync held 1, b_in=5 then -3 -> b_in_notify falls and b_out_notify rises one cycle after the 2nd transfer; b_out element0=5, element1=-3 (0xFFFFFFFD).
- DEPTH=4, REVERSE=1, inputs 1,2,3,4 -> b_out elements [0..3] = 4,3,2,1; b_out_notify=1 exactly 1 cycle after the 4th transfer.
- Backpressure: array full, b_out_sync=0 for 10 cycles, b_in_sync=1 with b_in=99 -> b_out unchanged, b_in_notify=0 throughout. Then b_out_sync=1 for 1 cycle -> b_in_notify=1 the next cycle, b_out_notify=0.
- CLEAR_ON_SEND=1, DEPTH=3, inputs 7,8,9, output transfer -> b_out=0 the next cycle. CLEAR_ON_SEND=0 repeat -> b_out stays 7,8,9 until overwritten element by element.
- Reset mid-fill: DEPTH=4 after 2 transfers (10,20), assert rst between clock edges -> b_out=0, b_in_notify=1, b_out_notify=0 immediately. The next 4 inputs 1..4 land at indices 0..3.
- Back-to-back streaming, WIDTH=8, DEPTH=2, both syncs tied high, inputs 0x7F,0x80,0x01,0x02 -> arrays {0x7F,0x80} then {0x01,0x02} delivered; 3-cycle period per array; the notifies are never high together.
